// File: rtl/sram_sched_pkg.sv
// Shared types for the SRAM write scheduler: FSM encodings and the queued command word.
// Command word layout is {sel, addr[15:0], data[15:0]}, sel in bit 32.
package sram_sched_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 8;

    typedef logic [1:0] state_t;
    localparam state_t IDLE   = 2'd0;
    localparam state_t SETUP  = 2'd1;
    localparam state_t STROBE = 2'd2;
    localparam state_t HOLD   = 2'd3;

    typedef struct packed {
        logic              sel;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    function automatic cmd_t pack_cmd(input logic sel, input logic [ADDR_W-1:0] addr,
                                      input logic [DATA_W-1:0] data);
        cmd_t c;
        c.sel  = sel;
        c.addr = addr;
        c.data = data;
        return c;
    endfunction

endpackage

// File: rtl/sync_cmd_fifo.sv
// Generic DEPTH x W synchronous FIFO; push visible at the read port one cycle later (no fall-through).
// Backpressure: push ignored while full, pop ignored while empty; push+pop together keeps level.
module sync_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 33
) (
    input  logic                     clk_sys,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (level == LVL_FULL);
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    // Storage needs no reset: pointers and level define what is valid.
    always_ff @(posedge clk_sys) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/sram_write_scheduler.sv
// Queues SPI write commands and plays them into two SRAMs with setup/strobe/hold timing; pins registered, 1-cycle latency.
// Backpressure: cmd_ready = !full; playback counter of the target SRAM is stalled via holdN for the whole access.
module sram_write_scheduler
    import sram_sched_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int SETUP_CYC = 2,
    parameter int WE_CYC    = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                     clk_sys,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_sel,
    input  logic [ADDR_W-1:0]        cmd_addr,
    input  logic [DATA_W-1:0]        cmd_data,
    input  logic [ADDR_W-1:0]        play_addr0,
    input  logic [ADDR_W-1:0]        play_addr1,
    output logic [ADDR_W-1:0]        sram0_addr,
    output logic [DATA_W-1:0]        sram0_dout,
    output logic                     sram0_oe,
    output logic                     sram0_we_n,
    output logic [ADDR_W-1:0]        sram1_addr,
    output logic [DATA_W-1:0]        sram1_dout,
    output logic                     sram1_oe,
    output logic                     sram1_we_n,
    output logic                     hold0,
    output logic                     hold1,
    output logic                     busy,
    output logic                     wr_done,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    cmd_t             fifo_rdat;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    cmd_t             act;
    cmd_t             act_nxt;
    logic             done_nxt;
    logic             drive0;
    logic             drive1;
    logic             strobe_nxt;

    sync_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk_sys  (clk_sys),
        .rst      (rst),
        .push     (cmd_valid),
        .push_dat (pack_cmd(cmd_sel, cmd_addr, cmd_data)),
        .pop      (pop),
        .pop_dat  (fifo_rdat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    assign cmd_ready = !fifo_full;
    assign busy      = (state != IDLE) || !fifo_empty;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        act_nxt   = act;
        pop       = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    act_nxt   = fifo_rdat;
                    state_nxt = SETUP;
                    cnt_nxt   = CNT_W'(SETUP_CYC - 1);
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_nxt = STROBE;
                    cnt_nxt   = CNT_W'(WE_CYC - 1);
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            STROBE: begin
                if (cnt == '0) begin
                    state_nxt = HOLD;
                    cnt_nxt   = CNT_W'(HOLD_CYC - 1);
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
        endcase
    end

    // Pins are registered from next-state so they line up with the state they describe.
    assign drive0     = (state_nxt != IDLE) && !act_nxt.sel;
    assign drive1     = (state_nxt != IDLE) &&  act_nxt.sel;
    assign strobe_nxt = (state_nxt == STROBE);

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            act   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            act   <= act_nxt;
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            sram0_we_n <= 1'b1;
            sram0_oe   <= 1'b0;
            sram0_dout <= '0;
            hold0      <= 1'b0;
            sram1_we_n <= 1'b1;
            sram1_oe   <= 1'b0;
            sram1_dout <= '0;
            hold1      <= 1'b0;
            wr_done    <= 1'b0;
        end else begin
            sram0_we_n <= !(drive0 && strobe_nxt);
            sram0_oe   <= drive0;
            sram0_dout <= drive0 ? act_nxt.data : '0;
            hold0      <= drive0;
            sram1_we_n <= !(drive1 && strobe_nxt);
            sram1_oe   <= drive1;
            sram1_dout <= drive1 ? act_nxt.data : '0;
            hold1      <= drive1;
            wr_done    <= done_nxt;
        end
    end

    // No reset: in reset the FSM is idle and the FIFO empty, so these simply track playback.
    always_ff @(posedge clk_sys) begin
        sram0_addr <= drive0 ? act_nxt.addr : play_addr0;
        sram1_addr <= drive1 ? act_nxt.addr : play_addr1;
    end

endmodule

// File: tb/tb_sram_write_scheduler.sv
// Directed bench with write scoreboard for sram_write_scheduler (default timing plus a 1/1/1 instance).
module tb_sram_write_scheduler;

    localparam int A_SETUP = 2;
    localparam int A_WE    = 2;
    localparam int A_HOLD  = 1;
    localparam int A_LEN   = A_SETUP + A_WE + A_HOLD;

    logic        clk_sys = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_valid_b, cmd_sel;
    logic [15:0] cmd_addr, cmd_data;
    logic [15:0] play_addr0 = 16'h0100;
    logic [15:0] play_addr1 = 16'h8000;

    logic        cmd_ready, sram0_oe, sram0_we_n, sram1_oe, sram1_we_n;
    logic [15:0] sram0_addr, sram0_dout, sram1_addr, sram1_dout;
    logic        hold0, hold1, busy, wr_done;
    logic [2:0]  fifo_level;

    logic        b_cmd_ready, b_sram0_oe, b_sram0_we_n, b_sram1_oe, b_sram1_we_n;
    logic [15:0] b_sram0_addr, b_sram0_dout, b_sram1_addr, b_sram1_dout;
    logic        b_hold0, b_hold1, b_busy, b_wr_done;
    logic [2:0]  b_fifo_level;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int last_acc_cyc, acc, d0;
    int strobe_cyc_q[$];
    logic [32:0] exp_q[$];
    logic [31:0] expb_q[$];
    logic [15:0] tmp16;

    sram_write_scheduler #(.DEPTH(4), .SETUP_CYC(A_SETUP), .WE_CYC(A_WE), .HOLD_CYC(A_HOLD)) dut (
        .clk_sys(clk_sys), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .play_addr0(play_addr0), .play_addr1(play_addr1),
        .sram0_addr(sram0_addr), .sram0_dout(sram0_dout), .sram0_oe(sram0_oe), .sram0_we_n(sram0_we_n),
        .sram1_addr(sram1_addr), .sram1_dout(sram1_dout), .sram1_oe(sram1_oe), .sram1_we_n(sram1_we_n),
        .hold0(hold0), .hold1(hold1), .busy(busy), .wr_done(wr_done), .fifo_level(fifo_level)
    );

    sram_write_scheduler #(.DEPTH(4), .SETUP_CYC(1), .WE_CYC(1), .HOLD_CYC(1)) dut_b (
        .clk_sys(clk_sys), .rst(rst), .cmd_valid(cmd_valid_b), .cmd_ready(b_cmd_ready),
        .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .play_addr0(play_addr0), .play_addr1(play_addr1),
        .sram0_addr(b_sram0_addr), .sram0_dout(b_sram0_dout), .sram0_oe(b_sram0_oe), .sram0_we_n(b_sram0_we_n),
        .sram1_addr(b_sram1_addr), .sram1_dout(b_sram1_dout), .sram1_oe(b_sram1_oe), .sram1_we_n(b_sram1_we_n),
        .hold0(b_hold0), .hold1(b_hold1), .busy(b_busy), .wr_done(b_wr_done), .fifo_level(b_fifo_level)
    );

    initial forever #5 clk_sys = ~clk_sys;
    initial forever begin @(posedge clk_sys); cyc++; end
    // Playback counters advance mid-cycle so a registered copy lags by exactly one count.
    initial forever begin
        @(posedge clk_sys); #3;
        play_addr0 = play_addr0 + 16'd1;
        play_addr1 = play_addr1 + 16'd1;
    end
    initial begin #200000; $display("FAIL watchdog observed=timeout expected=finish"); $fatal(1); end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_cmd(input logic sel, input logic [15:0] a, input logic [15:0] d);
        bit ok;
        ok = 0;
        cmd_sel = sel; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (cmd_ready) begin ok = 1; @(posedge clk_sys); #1; break; end
            @(posedge clk_sys); #1;
        end
        cmd_valid = 1'b0;
        if (ok) begin exp_q.push_back({sel, a, d}); last_acc_cyc = cyc; end
        chk("push_accepted", ok, 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk_sys); #1;
            if (!busy && exp_q.size() == 0) begin ok = 1; break; end
        end
        @(negedge clk_sys); #1;
        chk("idle_reached", ok, 1);
    endtask

    // what: 0 = hold0 high, 1 = sram1_we_n low, 2 = wr_done high
    task automatic wait_until(input int what);
        bit ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if ((what == 0 && hold0) || (what == 1 && !sram1_we_n) || (what == 2 && wr_done)) begin
                ok = 1; break;
            end
            @(posedge clk_sys); #1;
        end
        chk("wait_event", ok, 1);
    endtask

    // Access monitor for the default-timing instance.
    logic [1:0]  we_v, hold_v, oe_v;
    logic [15:0] addr_v[2], dout_v[2], cap_addr[2], cap_dout[2];
    int          hold_len[2], we_len[2], unstable[2];
    logic        prev_we[2], prev_hold[2], prev_done;
    logic [32:0] sb_word;

    always_comb begin
        we_v = {sram1_we_n, sram0_we_n};
        hold_v = {hold1, hold0};
        oe_v = {sram1_oe, sram0_oe};
        addr_v[0] = sram0_addr; addr_v[1] = sram1_addr;
        dout_v[0] = sram0_dout; dout_v[1] = sram1_dout;
    end

    always @(negedge clk_sys) begin
        if (rst) begin
            for (int s = 0; s < 2; s++) begin
                prev_we[s] = 1'b1; prev_hold[s] = 1'b0; hold_len[s] = 0; we_len[s] = 0; unstable[s] = 0;
            end
            prev_done = 1'b0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (hold_v[s]) begin
                    if (!prev_hold[s]) begin
                        hold_len[s] = 0; we_len[s] = 0; unstable[s] = 0;
                        cap_addr[s] = addr_v[s]; cap_dout[s] = dout_v[s];
                    end
                    hold_len[s]++;
                    if (addr_v[s] !== cap_addr[s] || dout_v[s] !== cap_dout[s] || !oe_v[s] || hold_v[1-s])
                        unstable[s]++;
                    if (!we_v[s]) begin
                        if (prev_we[s]) begin
                            strobe_cyc_q.push_back(cyc);
                            chk("setup_len", hold_len[s] - 1, A_SETUP);
                            chk("sb_nonempty", exp_q.size() > 0, 1);
                            if (exp_q.size() > 0) begin
                                sb_word = {(s == 1), addr_v[s], dout_v[s]};
                                chk("sb_word", sb_word, exp_q.pop_front());
                            end
                        end
                        we_len[s]++;
                    end
                end else if (prev_hold[s]) begin
                    chk("we_len", we_len[s], A_WE);
                    chk("hold_len", hold_len[s], A_LEN);
                    chk("pins_stable", unstable[s], 0);
                    chk("done_at_end", wr_done, 1);
                end
                prev_we[s] = we_v[s];
                prev_hold[s] = hold_v[s];
            end
            if (wr_done) begin
                done_cnt++;
                chk("done_width", prev_done, 0);
            end
            prev_done = wr_done;
        end
    end

    int b_low, b_hold, b_h1, b_done;
    int b_st[$];
    logic prev_b;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_valid_b = 1'b0;
        cmd_sel = 1'b0; cmd_addr = '0; cmd_data = '0;
        repeat (2) @(posedge clk_sys);
        @(negedge clk_sys); #1;
        chk("rst_we0", sram0_we_n, 1);
        chk("rst_we1", sram1_we_n, 1);
        chk("rst_oe0", sram0_oe, 0);
        chk("rst_oe1", sram1_oe, 0);
        chk("rst_dout0", sram0_dout, 0);
        chk("rst_hold", {hold1, hold0}, 0);
        chk("rst_done", wr_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ready", cmd_ready, 1);
        tmp16 = play_addr0 - 16'd1; chk("rst_addr0", sram0_addr, tmp16);
        tmp16 = play_addr1 - 16'd1; chk("rst_addr1", sram1_addr, tmp16);
        @(posedge clk_sys); #1; rst = 1'b0;
        @(posedge clk_sys); #1;

        // single write
        strobe_cyc_q.delete(); d0 = done_cnt;
        push_cmd(1'b0, 16'h0012, 16'hBEEF);
        acc = last_acc_cyc;
        wait_idle();
        chk("sw_strobes", strobe_cyc_q.size(), 1);
        if (strobe_cyc_q.size() == 1) chk("sw_strobe_ofs", strobe_cyc_q[0] - acc, 3);
        chk("sw_done", done_cnt - d0, 1);

        // burst behind a busy FSM
        strobe_cyc_q.delete(); d0 = done_cnt;
        push_cmd(1'b0, 16'h00FF, 16'h0000);
        wait_until(0);
        for (int i = 1; i <= 4; i++) push_cmd(1'b0, 16'h0200 + 16'(i), 16'(i));
        chk("burst_level", fifo_level, 4);
        chk("burst_ready", cmd_ready, 0);
        push_cmd(1'b0, 16'h0205, 16'h0005);
        wait_idle();
        chk("burst_done", done_cnt - d0, 6);
        chk("burst_strobes", strobe_cyc_q.size(), 6);
        for (int i = 1; i < strobe_cyc_q.size(); i++) chk("burst_pitch", strobe_cyc_q[i] - strobe_cyc_q[i-1], 6);

        // alternating targets
        d0 = done_cnt;
        push_cmd(1'b0, 16'h0300, 16'hA0A0);
        push_cmd(1'b1, 16'h0301, 16'h5151);
        push_cmd(1'b0, 16'h0302, 16'hC3C3);
        push_cmd(1'b1, 16'h0303, 16'h3C3C);
        for (int i = 0; i < 24; i++) begin
            @(negedge clk_sys); #1;
            if (hold0) begin
                chk("alt_hold1", hold1, 0);
                tmp16 = play_addr1 - 16'd1; chk("alt_track1", sram1_addr, tmp16);
            end
            if (hold1) begin
                chk("alt_hold0", hold0, 0);
                tmp16 = play_addr0 - 16'd1; chk("alt_track0", sram0_addr, tmp16);
            end
        end
        wait_idle();
        chk("alt_done", done_cnt - d0, 4);

        // reset during strobe
        push_cmd(1'b1, 16'h0400, 16'h1111);
        push_cmd(1'b0, 16'h0401, 16'h2222);
        wait_until(1);
        d0 = done_cnt;
        #1 rst = 1'b1;
        #1;
        chk("abort_we1", sram1_we_n, 1);
        chk("abort_oe1", sram1_oe, 0);
        chk("abort_hold1", hold1, 0);
        chk("abort_level", fifo_level, 0);
        chk("abort_busy", busy, 0);
        @(posedge clk_sys); #1; rst = 1'b0;
        exp_q.delete();
        repeat (3) begin @(posedge clk_sys); #1; end
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_idle", busy, 0);
        push_cmd(1'b1, 16'h0410, 16'h7777);
        wait_idle();
        chk("abort_recover", done_cnt - d0, 1);

        // simultaneous push and pop at level 2
        d0 = done_cnt;
        push_cmd(1'b0, 16'h0500, 16'h0A00);
        wait_until(0);
        push_cmd(1'b0, 16'h0501, 16'h0A01);
        push_cmd(1'b1, 16'h0502, 16'h0A02);
        chk("pp_level_pre", fifo_level, 2);
        wait_until(2);
        chk("pp_level_at_pop", fifo_level, 2);
        push_cmd(1'b0, 16'h0503, 16'h0A03);
        chk("pp_level_post", fifo_level, 2);
        wait_idle();
        chk("pp_done", done_cnt - d0, 4);

        // 1/1/1 timing instance
        b_low = 0; b_hold = 0; b_h1 = 0; b_done = 0; prev_b = 1'b1;
        cmd_sel = 1'b0; cmd_addr = 16'h0600; cmd_data = 16'hD00D; cmd_valid_b = 1'b1;
        expb_q.push_back({16'h0600, 16'hD00D});
        @(posedge clk_sys); #1;
        cmd_addr = 16'h0601; cmd_data = 16'hF00F;
        expb_q.push_back({16'h0601, 16'hF00F});
        @(posedge clk_sys); #1;
        cmd_valid_b = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk_sys); #1;
            if (!b_sram0_we_n) begin
                if (prev_b) begin
                    b_st.push_back(cyc);
                    if (expb_q.size() > 0) chk("b_word", {b_sram0_addr, b_sram0_dout}, expb_q.pop_front());
                end
                b_low++;
            end
            if (b_hold0) b_hold++;
            if (b_hold1) b_h1++;
            if (b_wr_done) b_done++;
            prev_b = b_sram0_we_n;
        end
        chk("b_strobe_cycles", b_low, 2);
        chk("b_hold_cycles", b_hold, 6);
        chk("b_hold1_cycles", b_h1, 0);
        chk("b_done", b_done, 2);
        chk("b_strobes", b_st.size(), 2);
        if (b_st.size() == 2) chk("b_pitch", b_st[1] - b_st[0], 4);

        chk("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/sram_write_scheduler.md
Name: sram_write_scheduler

Overview:
- Sequences SPI-originated write commands into the two playback SRAMs with programmable address-setup, write-strobe and hold timing.
- Buffers commands in a small FIFO so back-to-back SPI frames are never dropped.
- Owns the SRAM address/data/WE pins. It muxes between the NCO-driven playback address and the write address, and stalls the matching playback counter for the duration of each access.
- Sits between the SPI command decoder and the SRAM pins; replaces direct pin drive from the decoder.

Parameters:
- DEPTH, 4, command FIFO depth (power of two, >= 2).
- SETUP_CYC, 2, cycles with address/data stable and WE_n high before the strobe (>= 1).
- WE_CYC, 2, cycles WE_n is held low (>= 1).
- HOLD_CYC, 1, cycles address/data remain driven after WE_n rises (>= 1).

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  write command present
- cmd_ready  out  1  FIFO can accept; transfer occurs when cmd_valid && cmd_ready
- cmd_sel  in  1  target: 0 = SRAM0, 1 = SRAM1
- cmd_addr  in  16  write address
- cmd_data  in  16  write data
- play_addr0  in  16  playback address from counter0
- play_addr1  in  16  playback address from counter1
- sram0_addr  out  16  SRAM0 address pins
- sram0_dout  out  16  SRAM0 data to tristate buffer
- sram0_oe  out  1  SRAM0 data-drive enable
- sram0_we_n  out  1  SRAM0 write strobe, active low
- sram1_addr, sram1_dout, sram1_oe, sram1_we_n: same as SRAM0 set, for SRAM1
- hold0  out  1  stall counter0 while SRAM0 is being written
- hold1  out  1  stall counter1 while SRAM1 is being written
- busy  out  1  FSM not IDLE or FIFO not empty
- wr_done  out  1  one-cycle pulse when an access completes
- fifo_level  out  $clog2(DEPTH)+1  entries currently queued

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - FIFO flushed; state IDLE; fifo_level = 0.
  - we_n = 1, oe = 0, dout = 0, hold = 0, wr_done = 0, busy = 0 for both SRAMs.
  - sramN_addr follows play_addrN.
  - Reset mid-access aborts the access: WE_n rises in the same instant and the entry is lost.
- FIFO:
  - cmd_ready = !full.
  - Push is ignored when full, so a command at full is not accepted.
  - Push and pop in the same cycle are allowed when neither full nor empty; fifo_level is unchanged.
  - Push to an empty FIFO is visible to the FSM one cycle later (no fall-through).
- FSM states: IDLE, SETUP, STROBE, HOLD.
  - IDLE: if FIFO not empty, pop the head into the active register {sel, addr, data} and go to SETUP, with phase counter = SETUP_CYC-1.
  - SETUP: sel'd SRAM addr = active addr, dout = active data, oe = 1, we_n = 1, hold = 1. At counter 0, go to STROBE with counter = WE_CYC-1.
  - STROBE: as SETUP but we_n = 0. At counter 0, go to HOLD with counter = HOLD_CYC-1.
  - HOLD: we_n = 1, oe/addr/dout still driven, hold = 1. At counter 0, go to IDLE and pulse wr_done for one cycle.
- Output timing:
  - All pin outputs are registered.
  - Non-selected SRAM: oe = 0, we_n = 1, addr = its play_addr (registered, 1-cycle latency), hold = 0.
- Access length: exactly SETUP_CYC + WE_CYC + HOLD_CYC cycles of hold assertion, plus one IDLE cycle between consecutive accesses. This guarantees we_n high for >= HOLD_CYC + 1 + SETUP_CYC cycles between strobes. Default: 5-cycle hold, 6-cycle command pitch.
- busy = (state != IDLE) || !empty.
- A new push during an access never disturbs the active register.

Decomposition:
- Package sram_sched_pkg:
  - state enum: IDLE = 2'd0, SETUP = 2'd1, STROBE = 2'd2, HOLD = 2'd3.
  - cmd word layout (33 bits): bit 32 = sel, bits 31:16 = addr, bits 15:0 = data.
  - ADDR_W = 16, DATA_W = 16.
- Sub-module sync_cmd_fifo: generic DEPTH x 33-bit synchronous FIFO with full/empty/level and the same clock and reset.
- FSM, phase counter and pin muxing stay in the top.

Test Plan:
- Single write: sel = 0, addr = 16'h0012, data = 16'hBEEF, defaults.
  - sram0_we_n low for exactly 2 cycles, starting 3 cycles after pop.
  - addr/dout stable from SETUP through HOLD; hold0 high for 5 cycles; hold1 = 0; one wr_done pulse.
- Burst of 5 pushes with DEPTH = 4 and no pops possible (FSM busy): cmd_ready drops after the 4th buffered entry.
  - The 5th is held off until a pop; all 5 complete in order (pitch 6 cycles).
  - Pin data matches 16'h0001..16'h0005.
- Alternating targets SRAM0/SRAM1: while SRAM0 is being written, sram1_addr tracks play_addr1 (incrementing by 1/cycle) with 1-cycle latency.
  - hold1 = 0 throughout, and vice versa.
- Reset asserted during STROBE (rst high for 1 cycle):
  - we_n = 1 and oe = 0 immediately; fifo_level = 0; no wr_done.
  - After release the FSM is IDLE and the next command completes normally.
- Parameter sweep SETUP_CYC = 1, WE_CYC = 1, HOLD_CYC = 1: strobe is 1 cycle, hold is 3 cycles, pitch is 4 cycles.
- Simultaneous push and pop at fifo_level = 2: level stays 2 and order is preserved.
